// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-FF input sync, 3-sample majority vote, runtime parity/stop config,
// break detection and an AXI4-Stream output FIFO.
module uart_rx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_error,
  output logic                          parity_error,
  output logic                          overrun_error,
  output logic                          break_detect
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_e;

  state_e                    state_q, state_d;
  logic                      rx_meta_q, rxs_q, prev_rx_q;
  logic [1:0]                primed_q;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d, clk_cnt_q, clk_cnt_d;
  logic [2:0]                tick_q, tick_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      s3_q, s3_d, s4_q, s4_d, par_q, par_d;
  logic                      stop_fault_q, stop_fault_d, stop_cnt_q, stop_cnt_d;
  logic [1:0]                par_mode_q, par_mode_d;
  logic                      two_stop_q, two_stop_d;
  logic                      fe_d, pe_d, brk_d, ovr_d, push_req;
  logic                      tick_evt, samp, bit_end, maj, par_en, par_exp, fault_now;

  // primed_q keeps prev_rx low until rxs holds a real line sample, so a line low
  // through reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      prev_rx_q <= 1'b0;
      primed_q  <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments keep each flop sampling the pre-edge value of the one before it.
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
      primed_q  <= {primed_q[0], 1'b1};
      prev_rx_q <= rxs_q & primed_q[1];
    end
  end

  assign tick_evt  = (clk_cnt_q == div_q);
  assign samp      = tick_evt && (tick_q == 3'd5);
  assign bit_end   = tick_evt && (tick_q == 3'd7);
  assign maj       = (s3_q & s4_q) | (s3_q & rxs_q) | (s4_q & rxs_q);
  assign par_en    = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  assign par_exp   = (^shift_q) ^ (par_mode_q == 2'b01);
  assign fault_now = stop_fault_q | ~maj;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    div_d        = div_q;
    clk_cnt_d    = clk_cnt_q;
    tick_d       = tick_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    s3_d         = s3_q;
    s4_d         = s4_q;
    par_d        = par_q;
    stop_fault_d = stop_fault_q;
    stop_cnt_d   = stop_cnt_q;
    par_mode_d   = par_mode_q;
    two_stop_d   = two_stop_q;
    fe_d         = 1'b0;
    pe_d         = 1'b0;
    brk_d        = 1'b0;
    push_req     = 1'b0;

    if (state_q != IDLE && state_q != BRK_WAIT) begin
      clk_cnt_d = tick_evt ? '0 : clk_cnt_q + PRESCALE_WIDTH'(1);
      if (tick_evt) tick_d = tick_q + 3'd1;
      if (tick_evt && tick_q == 3'd3) s3_d = rxs_q;
      if (tick_evt && tick_q == 3'd4) s4_d = rxs_q;
    end

    case (state_q)
      IDLE: begin
        if (prev_rx_q && !rxs_q) begin
          state_d      = START;
          clk_cnt_d    = '0;
          tick_d       = 3'd0;
          div_d        = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
          par_mode_d   = parity_mode;
          two_stop_d   = stop_bits;
          bit_cnt_d    = '0;
          stop_cnt_d   = 1'b0;
          stop_fault_d = 1'b0;
          par_d        = 1'b0;
        end
      end
      START: begin
        if (samp && maj)  state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (samp) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_WIDTH-1)) state_d = par_en ? PARITY : STOP;
          else                                bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      PARITY: begin
        if (samp)    par_d   = maj;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (samp) begin
          stop_fault_d = fault_now;
          if (stop_cnt_q == two_stop_q) begin
            state_d = IDLE;
            if ((shift_q == '0) && fault_now && !(par_en && par_q)) begin
              brk_d   = 1'b1;
              state_d = BRK_WAIT;
            end else if (fault_now)                 fe_d     = 1'b1;
            else if (par_en && (par_q != par_exp))  pe_d     = 1'b1;
            else                                    push_req = 1'b1;
          end
        end else if (bit_end) begin
          stop_cnt_d = 1'b1;
        end
      end
      BRK_WAIT: if (rxs_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      clk_cnt_q     <= '0;
      tick_q        <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      s3_q          <= 1'b0;
      s4_q          <= 1'b0;
      par_q         <= 1'b0;
      stop_fault_q  <= 1'b0;
      stop_cnt_q    <= 1'b0;
      par_mode_q    <= 2'b00;
      two_stop_q    <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      clk_cnt_q     <= clk_cnt_d;
      tick_q        <= tick_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      s3_q          <= s3_d;
      s4_q          <= s4_d;
      par_q         <= par_d;
      stop_fault_q  <= stop_fault_d;
      stop_cnt_q    <= stop_cnt_d;
      par_mode_q    <= par_mode_d;
      two_stop_q    <= two_stop_d;
      frame_error   <= fe_d;
      parity_error  <= pe_d;
      overrun_error <= ovr_d;
      break_detect  <= brk_d;
    end
  end

  assign busy = (state_q != IDLE);

  // Output FIFO: a full FIFO still accepts a push when the head is popped in the same cycle.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  pop, push, full;

  assign full  = (count_q == FULL_CNT);
  assign pop   = (count_q != '0) && m_axis_tready;
  assign push  = push_req && (!full || pop);
  assign ovr_d = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; tdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: bytes expected on the stream side are queued as frames
// are driven and compared when popped; error pulses are counted by a negedge monitor.
module tb_uart_rx_fifo;

  localparam int BIT = 32;  // prescale 4 -> 8 ticks x 4 clocks

  logic        clk = 1'b0;
  logic        rst, rxd, stop_bits, m_axis_tready;
  logic [15:0] prescale;
  logic [1:0]  parity_mode;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, busy, frame_error, parity_error, overrun_error, break_detect;
  logic [4:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int fe_n = 0, pe_n = 0, ov_n = 0, brk_n = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (prescale),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .overrun_error (overrun_error),
    .break_detect  (break_detect)
  );

  always @(negedge clk) begin
    if (frame_error)   fe_n++;
    if (parity_error)  pe_n++;
    if (overrun_error) ov_n++;
    if (break_detect)  brk_n++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] pm, input logic two,
                            input logic par_flip, input logic stop_val, input logic expect_push);
    logic par;
    par = (^data) ^ (pm == 2'b01);
    if (expect_push) exp_q.push_back(data);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (pm == 2'b01 || pm == 2'b10) drive_bit(par ^ par_flip);
    drive_bit(stop_val);
    if (two) drive_bit(stop_val);
    drive_bit(1'b1);
  endtask

  task automatic pop_check(input string tag);
    int         waited;
    logic [7:0] exp;
    waited = 0;
    while (!m_axis_tvalid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, {24'd0, m_axis_tdata}, {24'd0, exp});
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
  endtask

  initial begin
    int flags_before;
    rst = 1'b1; rxd = 1'b0; m_axis_tready = 1'b0;
    prescale = 16'd4; parity_mode = 2'b00; stop_bits = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state, with the line held low through reset
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata",  {24'd0, m_axis_tdata}, 32'd0);
    check("rst_count",  {27'd0, fifo_count}, 32'd0);
    check("rst_flags",  {28'd0, frame_error, parity_error, overrun_error, break_detect}, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("low_thru_rst_busy", {31'd0, busy}, 32'd0);
    check("low_thru_rst_brk",  brk_n, 0);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);

    // T1: 0xA5, no parity, one stop bit
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t1_count", {27'd0, fifo_count}, 32'd1);
    check("t1_flags", fe_n + pe_n + ov_n + brk_n, 0);
    pop_check("t1_data");
    check("t1_empty", {31'd0, m_axis_tvalid}, 32'd0);

    // T2: even parity, two stop bits; then a parity-flipped resend
    parity_mode = 2'b10; stop_bits = 1'b1;
    send_frame(8'h3C, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3D, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t2_count", {27'd0, fifo_count}, 32'd2);
    send_frame(8'h3D, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t2_parity_err", pe_n, 1);
    check("t2_count_kept", {27'd0, fifo_count}, 32'd2);
    pop_check("t2_first");
    pop_check("t2_second");

    // T3: start-bit glitch, then a data-bit spike that majority voting must reject
    parity_mode = 2'b00; stop_bits = 1'b0;
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_busy_on_edge", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT - 8) @(negedge clk);
    check("t3_glitch_idle", {31'd0, busy}, 32'd0);
    check("t3_glitch_flags", fe_n + pe_n + ov_n + brk_n, 1);
    check("t3_glitch_count", {27'd0, fifo_count}, 32'd0);
    repeat (BIT) @(negedge clk);
    exp_q.push_back(8'h00);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rxd = 1'b0;
    repeat (22) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT - 23) @(negedge clk);
    for (int i = 3; i < 8; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    pop_check("t3_spike");

    // T4: bad stop bit, then a long break, then normal reception
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_frame_err", fe_n, 1);
    check("t4_no_push", {27'd0, fifo_count}, 32'd0);
    rxd = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    check("t4_break_once", brk_n, 1);
    check("t4_break_not_frame", fe_n, 1);
    check("t4_brk_wait_busy", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("t4_idle_after_brk", {31'd0, busy}, 32'd0);
    send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    pop_check("t4_after_break");

    // T5: fill past capacity with tready low
    for (int i = 0; i < 17; i++) send_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, i < 16);
    check("t5_full_count", {27'd0, fifo_count}, 32'd16);
    check("t5_overrun", ov_n, 1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("t5_pop%0d", i));
    check("t5_drained", {31'd0, m_axis_tvalid}, 32'd0);

    // T6: reset in the middle of data bit 4 with a byte queued
    send_frame(8'h77, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t6_queued", {27'd0, fifo_count}, 32'd1);
    flags_before = fe_n + pe_n + ov_n + brk_n;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rxd = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_count",  {27'd0, fifo_count}, 32'd0);
    check("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("t6_rst_tdata",  {24'd0, m_axis_tdata}, 32'd0);
    check("t6_rst_busy",   {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (BIT) @(negedge clk);
    check("t6_no_flags", fe_n + pe_n + ov_n + brk_n, flags_before);
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    pop_check("t6_after_rst");
    check("t6_empty", {27'd0, fifo_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
